sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_pkg.sv | 12 +
 rtl/sram_array.sv | 64 ++++++
 rtl/sram_ctrl.sv | 97 +++++++++
 tb/tb_sram_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and default sizing for the SRAM controller slice.
package sram_pkg;

   localparam int unsigned DEFAULT_DATA_W = 8;
   localparam int unsigned DEFAULT_ADDR_W = 3;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_e;

endpackage

// File: rtl/sram_array.sv
// Storage array with write port and either registered or combinational read.
// Optional macro SRAM_BYPASS_EN: write-first forwarding on a same-address
// read/write collision (registered read only).
module sram_array
   import sram_pkg::*;
#(
   parameter int unsigned DATA_W  = DEFAULT_DATA_W,
   parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
   parameter int unsigned SYNC_RD = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

`ifdef SRAM_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic [DATA_W-1:0] mem [DEPTH];

   // Array write; contents are not reset, the controller sweeps them to zero.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   if (SYNC_RD != 0) begin : g_sync_rd
      // Registered read; data holds while no read is accepted.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
         end else begin
            rd_valid <= re;
            if (re) begin
               if (BYPASS && we && (waddr == raddr)) begin
                  rd_data <= wdata;
               end else begin
                  rd_data <= mem[raddr];
               end
            end
         end
      end
   end else begin : g_comb_rd
      // Combinational read shows the stored word until the write edge.
      always_comb begin
         rd_valid = re;
         rd_data  = mem[raddr];
      end
   end

endmodule

// File: rtl/sram_ctrl.sv
// SRAM controller: post-reset/on-demand clear sweep plus gated read/write
// access to sram_array. Optional macro SRAM_BYPASS_EN selects write-first
// collision behaviour for the registered read path.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int unsigned DATA_W  = DEFAULT_DATA_W,
   parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
   parameter int unsigned SYNC_RD = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   state_e            state;
   logic [ADDR_W-1:0] ptr;

   logic              arr_we;
   logic [ADDR_W-1:0] arr_waddr;
   logic [DATA_W-1:0] arr_wdata;
   logic              arr_re;

   // Clear sequencer: sweep every word once, then serve requests until clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CLEAR;
         ptr   <= '0;
         busy  <= 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               ptr <= ptr + ADDR_W'(1);
               if (ptr == ADDR_W'(DEPTH - 1)) begin
                  state <= READY;
                  busy  <= 1'b0;
               end
            end
            READY: begin
               if (clr) begin
                  state <= CLEAR;
                  ptr   <= '0;
                  busy  <= 1'b1;
               end
            end
            default: begin
               state <= CLEAR;
               ptr   <= '0;
               busy  <= 1'b1;
            end
         endcase
      end
   end

   // Request gating: the sweep owns the write port, reads are blocked while clearing.
   always_comb begin
      arr_we    = 1'b0;
      arr_waddr = wr_addr;
      arr_wdata = wr_data;
      arr_re    = 1'b0;
      if (state == CLEAR) begin
         arr_we    = 1'b1;
         arr_waddr = ptr;
         arr_wdata = '0;
      end else begin
         arr_we = wr_en;
         arr_re = rd_en;
      end
   end

   sram_array #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .SYNC_RD (SYNC_RD)
   ) u_array (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (arr_we),
      .waddr    (arr_waddr),
      .wdata    (arr_wdata),
      .re       (arr_re),
      .raddr    (rd_addr),
      .rd_valid (rd_valid),
      .rd_data  (rd_data)
   );

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: registered-read and combinational-read
// instances share stimulus and are checked against a word-level model.
module tb_sram_ctrl;

`ifdef SRAM_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       clr;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [2:0] rd_addr;

   logic       s_valid, a_valid;
   logic [7:0] s_data, a_data;
   logic       s_busy, a_busy;

   int         checks;
   int         failures;

   logic [7:0] model [8];
   int         busy_left;
   logic [7:0] hold;

   sram_ctrl #(.DATA_W(8), .ADDR_W(3), .SYNC_RD(1)) u_sync (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_valid(s_valid), .rd_data(s_data), .busy(s_busy)
   );

   sram_ctrl #(.DATA_W(8), .ADDR_W(3), .SYNC_RD(0)) u_async (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_valid(a_valid), .rd_data(a_data), .busy(a_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus; checks the combinational view before the edge and
   // the registered view after it.
   task automatic step(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic re, input logic [2:0] ra, input logic c);
      logic       exp_v;
      logic [7:0] exp_d;
      wr_en = we; wr_addr = wa; wr_data = wd;
      rd_en = re; rd_addr = ra; clr = c;
      #1;
      exp_v = re && (busy_left == 0);
      check("async_valid", 32'(a_valid), 32'(exp_v));
      if (exp_v) check("async_data", 32'(a_data), 32'(model[ra]));
      exp_d = hold;
      if (exp_v) exp_d = (BYP && we && (wa == ra)) ? wd : model[ra];
      @(posedge clk);
      #1;
      if (busy_left > 0) begin
         busy_left--;
      end else begin
         if (we) model[wa] = wd;
         if (c) begin
            for (int i = 0; i < 8; i++) model[i] = 8'h00;
            busy_left = 8;
         end
      end
      hold = exp_d;
      check("sync_busy", 32'(s_busy), 32'(busy_left > 0));
      check("async_busy", 32'(a_busy), 32'(busy_left > 0));
      check("sync_valid", 32'(s_valid), 32'(exp_v));
      check("sync_data", 32'(s_data), 32'(exp_d));
   endtask

   // Runs idle-but-requesting cycles while busy and checks the busy length.
   task automatic count_busy(input string tag);
      int n;
      n = 0;
      while (s_busy === 1'b1 && n < 20) begin
         step(1'b1, 3'($urandom), 8'($urandom), 1'b1, 3'($urandom), 1'b0);
         n++;
      end
      check(tag, 32'(n), 32'd8);
   endtask

   // Asserts reset mid-cycle, checks outputs at once, releases after one edge.
   task automatic do_reset();
      rd_en = 1'b1;
      rst_n = 1'b0;
      #1;
      check("rst_sync_busy", 32'(s_busy), 32'd1);
      check("rst_async_busy", 32'(a_busy), 32'd1);
      check("rst_sync_valid", 32'(s_valid), 32'd0);
      check("rst_sync_data", 32'(s_data), 32'd0);
      check("rst_async_valid", 32'(a_valid), 32'd0);
      busy_left = 8;
      hold = 8'h00;
      for (int i = 0; i < 8; i++) model[i] = 8'h00;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b0; clr = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_en = 1'b0; rd_addr = '0;
      busy_left = 8; hold = 8'h00;
      @(posedge clk);
      #1;

      // Power-up clear, then every word reads zero.
      do_reset();
      count_busy("reset_busy_cycles");
      for (int a = 0; a < 8; a++) step(1'b0, 3'h0, 8'h00, 1'b1, 3'(a), 1'b0);

      // Write then read back with one-cycle latency.
      step(1'b1, 3'd5, 8'hA5, 1'b0, 3'd0, 1'b0);
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 1'b0);
      step(1'b0, 3'd0, 8'h00, 1'b0, 3'd1, 1'b0);

      // Same-address collision: old word or forwarded data.
      step(1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 1'b0);
      step(1'b1, 3'd2, 8'h3C, 1'b1, 3'd2, 1'b0);
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0);

      // Fill with FF, clear with a read in the clr cycle, writes dropped while busy.
      for (int a = 0; a < 8; a++) step(1'b1, 3'(a), 8'hFF, 1'b0, 3'd0, 1'b0);
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1);
      count_busy("clr_busy_cycles");
      for (int a = 0; a < 8; a++) step(1'b0, 3'h0, 8'h00, 1'b1, 3'(a), 1'b0);

      // Reset in the fourth cycle of a clear restarts a full sweep.
      step(1'b1, 3'd6, 8'h77, 1'b1, 3'd6, 1'b0);
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b0);
      do_reset();
      count_busy("midclear_reset_busy_cycles");

      // Combinational read of addr 7 in the same cycle.
      step(1'b1, 3'd7, 8'h5A, 1'b0, 3'd0, 1'b0);
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 1'b0);

      // Random traffic with occasional clears.
      for (int i = 0; i < 80; i++) begin
         step(1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom), 3'($urandom),
              1'($urandom_range(0, 15) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
